// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS-I subset core: PC, 32x32 register file, ALU and a control FSM
// sharing one instruction/data memory port with a req/ack handshake.
module multicycle_mips_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] out_alu,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sext;
  logic [31:0] bt;
  logic [31:0] mdr;
  logic [31:0] alu_reg;
  logic        retire_reg;
  // Cleared by reset so the port stays idle until the first clock edge after reset.
  logic        run;
  logic [31:0] rf [1:31];

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_branch;
  logic r_legal, legal;

  // Instruction classification from the latched IR
  always_comb begin
    is_rtype  = (opcode == OP_RTYPE);
    is_addi   = (opcode == OP_ADDI);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    is_beq    = (opcode == OP_BEQ);
    is_bne    = (opcode == OP_BNE);
    is_j      = (opcode == OP_J);
    is_branch = is_beq || is_bne;
    r_legal   = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                (funct == FN_OR)  || (funct == FN_SLT);
    legal     = (is_rtype && r_legal) || is_addi || is_lw || is_sw || is_branch || is_j;
  end

  // Register file read ports; $0 is hardwired to zero
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  always_comb begin
    rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
    rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];
  end

  // ALU: R-type ops, address/immediate add, and compare-by-subtract for branches
  logic [31:0] alu_result;
  logic        taken;
  always_comb begin
    alu_result = a + sext;
    if (is_rtype) begin
      case (funct)
        FN_ADD:  alu_result = a + b;
        FN_SUB:  alu_result = a - b;
        FN_AND:  alu_result = a & b;
        FN_OR:   alu_result = a | b;
        FN_SLT:  alu_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: alu_result = a + b;
      endcase
    end else if (is_branch) begin
      alu_result = a - b;
    end
    taken = is_beq ? (a == b) : (a != b);
  end

  // A memory access finishes only on an acked edge while actually requesting
  logic acc_done;
  assign acc_done = mem_req && mem_ack;

  // Instruction completion in the current state; registered into retire
  logic complete;
  always_comb begin
    complete = 1'b0;
    case (state)
      S_DECODE: complete = !legal && !HALT_ON_ILLEGAL;
      S_EXEC:   complete = is_branch || is_j;
      S_MEM:    complete = is_sw && acc_done;
      S_WB:     complete = 1'b1;
      default:  complete = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (acc_done) state_next = S_DECODE;
      S_DECODE: begin
        if (!legal) state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        else        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_branch || is_j)  state_next = S_FETCH;
        else if (is_lw || is_sw) state_next = S_MEM;
        else                     state_next = S_WB;
      end
      S_MEM:    if (acc_done) state_next = is_sw ? S_FETCH : S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // FSM outputs: memory port driven only in FETCH/MEM, idle during and right after reset
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    halted    = (state == S_HALT);
    if (run) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_addr = alu_reg;
          if (is_sw) begin
            mem_we    = 1'b1;
            mem_wdata = b;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: PC, IR, operand latches, ALU result, MDR, retire pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      pc4        <= 32'd0;
      ir         <= 32'd0;
      a          <= 32'd0;
      b          <= 32'd0;
      sext       <= 32'd0;
      bt         <= 32'd0;
      mdr        <= 32'd0;
      alu_reg    <= 32'd0;
      retire_reg <= 1'b0;
      run        <= 1'b0;
    end else begin
      run        <= 1'b1;
      retire_reg <= complete;
      case (state)
        S_FETCH: begin
          if (acc_done) begin
            ir  <= mem_rdata;
            pc4 <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a    <= rs_val;
          b    <= rt_val;
          sext <= imm_sext;
          bt   <= pc4 + {imm_sext[29:0], 2'b00};
          if (!legal && !HALT_ON_ILLEGAL) pc <= pc4;
        end
        S_EXEC: begin
          if (!is_j) alu_reg <= alu_result;
          if (is_branch) pc <= taken ? bt : pc4;
          if (is_j)      pc <= {pc4[31:28], ir[25:0], 2'b00};
        end
        S_MEM: begin
          if (acc_done) begin
            if (is_sw) pc <= pc4;
            else       mdr <= mem_rdata;
          end
        end
        S_WB: begin
          pc <= pc4;
        end
        default: ;
      endcase
    end
  end

  // Register file write-back: rd for R-type, rt for addi/lw; $0 writes dropped
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  assign wb_dest = is_rtype ? rd : rt;
  assign wb_data = is_lw ? mdr : alu_reg;

  // Register file storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) rf[i] <= 32'd0;
    end else if (state == S_WB && wb_dest != 5'd0) begin
      rf[wb_dest] <= wb_data;
    end
  end

  assign pc_out  = pc;
  assign out_alu = alu_reg;
  assign retire  = retire_reg;

endmodule
